interweave_sequencer: RTL and testbench

- Multi-cycle controller that drives the combinational interweave layer.
- Holds the activation vector in a register and fetches one packed weight word per step from an external weight store.
- Steps the trit (stride) select through NUM_LAYERS strides, repeated NUM_PASSES times, then hands the result vector downstream with a valid/ready handshake.
- Sits between the activation source and the layer datapath.

---
 rtl/interweave_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_interweave_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interweave_sequencer.sv
// ---------------------------------------------------------------------------
// interweave_sequencer
//
// Multi-cycle controller for the combinational interweave layer. It holds an
// activation vector in a state register and fetches one packed weight word
// per step from an external weight store. For each step it presents
// {x_state, w_reg, trit} to the layer and folds the layer result back into
// x_state. Steps run through NUM_LAYERS strides, repeated NUM_PASSES times.
// The final vector is then offered downstream with a valid/ready handshake.
//
// Optional feature, enabled by defining INTERWEAVE_SEQ_STALL_CNT_EN:
//   adds stall_cnt_out, a saturating count of WAIT_W cycles spent without a
//   weight response since the last accepted vector.
//
// Ports:
//   clk_in         clock
//   rst_in_n       asynchronous active-low reset
//   x_valid_in     input vector valid
//   x_ready_out    sequencer can accept a vector (IDLE only)
//   x_in           input activation vector
//   w_req_out      one-cycle weight fetch request
//   w_addr_out     step index of the requested weights
//   w_valid_in     weight word returned (sampled in WAIT_W only)
//   w_in           returned weight word
//   x_state_out    state register, to layer x
//   w_out          latched weights, to layer w
//   trit_out       stride select, to layer trit
//   layer_y_in     layer result
//   y_valid_out    result valid
//   y_ready_in     downstream accepts result
//   y_out          result vector (same as x_state_out)
//   busy_out       high in any state except IDLE
//   stall_cnt_out  (optional) weight-wait stall cycles since last accept
// ---------------------------------------------------------------------------
module interweave_sequencer #(
   parameter int X_SIZE     = 729,
   parameter int W_SIZE     = 2187,
   parameter int TRIT_SIZE  = 4,
   parameter int NUM_LAYERS = 5,
   parameter int NUM_PASSES = 2,
   parameter int ADDR_W     = ((NUM_LAYERS * NUM_PASSES) > 1) ?
                              $clog2(NUM_LAYERS * NUM_PASSES) : 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in_n,
   input  logic                 x_valid_in,
   output logic                 x_ready_out,
   input  logic [X_SIZE-1:0]    x_in,
   output logic                 w_req_out,
   output logic [ADDR_W-1:0]    w_addr_out,
   input  logic                 w_valid_in,
   input  logic [W_SIZE-1:0]    w_in,
   output logic [X_SIZE-1:0]    x_state_out,
   output logic [W_SIZE-1:0]    w_out,
   output logic [TRIT_SIZE-1:0] trit_out,
   input  logic [X_SIZE-1:0]    layer_y_in,
   output logic                 y_valid_out,
   input  logic                 y_ready_in,
   output logic [X_SIZE-1:0]    y_out,
   output logic                 busy_out
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
   ,
   output logic [31:0]          stall_cnt_out
`endif
);

   localparam int TOTAL = NUM_LAYERS * NUM_PASSES;
   localparam logic [ADDR_W-1:0]    LAST_STEP  = ADDR_W'(TOTAL - 1);
   localparam logic [TRIT_SIZE-1:0] LAST_LAYER = TRIT_SIZE'(NUM_LAYERS - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_W,
      APPLY,
      DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [X_SIZE-1:0]     x_state;
   logic [W_SIZE-1:0]     w_reg;
   logic [ADDR_W-1:0]     step;
   logic [TRIT_SIZE-1:0]  layer;

   logic                  accept;
   logic                  load_w;
   logic                  apply;

   // State register
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_nxt   = state;
      x_ready_out = 1'b0;
      w_req_out   = 1'b0;
      y_valid_out = 1'b0;
      busy_out    = 1'b1;
      accept      = 1'b0;
      load_w      = 1'b0;
      apply       = 1'b0;
      case (state)
         IDLE: begin
            x_ready_out = 1'b1;
            busy_out    = 1'b0;
            if (x_valid_in) begin
               accept    = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            w_req_out = 1'b1;
            state_nxt = WAIT_W;
         end
         WAIT_W: begin
            // A response arriving in any other state is dropped on purpose.
            if (w_valid_in) begin
               load_w    = 1'b1;
               state_nxt = APPLY;
            end
         end
         APPLY: begin
            apply     = 1'b1;
            state_nxt = (step == LAST_STEP) ? DONE : FETCH;
         end
         DONE: begin
            y_valid_out = 1'b1;
            if (y_ready_in) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Vector state, weight latch, step and stride counters
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         x_state <= '0;
         w_reg   <= '0;
         step    <= '0;
         layer   <= '0;
      end else begin
         if (accept) begin
            x_state <= x_in;
            step    <= '0;
            layer   <= '0;
         end else if (apply) begin
            x_state <= layer_y_in;
            // On the last step the counters hold, so step never passes TOTAL-1.
            if (step != LAST_STEP) begin
               step  <= step + ADDR_W'(1);
               layer <= (layer == LAST_LAYER) ? '0 : layer + TRIT_SIZE'(1);
            end
         end
         if (load_w) begin
            w_reg <= w_in;
         end
      end
   end

`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
   logic [31:0] stall_cnt;

   // Weight-wait stall counter, saturating at all ones
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         stall_cnt <= '0;
      end else if (accept) begin
         stall_cnt <= '0;
      end else if ((state == WAIT_W) && !w_valid_in && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_out = stall_cnt;
`endif

   assign w_addr_out  = step;
   assign trit_out    = layer;
   assign x_state_out = x_state;
   assign w_out       = w_reg;
   assign y_out       = x_state;

endmodule

// File: tb/tb_interweave_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interweave_sequencer
//
// Bench for interweave_sequencer. Two instances run side by side:
//   dut_a: NUM_LAYERS=2, NUM_PASSES=2 (TOTAL=4)
//   dut_b: NUM_LAYERS=3, NUM_PASSES=1 (TOTAL=3)
// The layer stub inverts the state vector, and the weight stores answer with
// w_in = requested step.
// ---------------------------------------------------------------------------
module tb_interweave_sequencer;

   localparam int TOTAL_A = 4;
   localparam int TOTAL_B = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // ---------------- instance A signals ----------------
   logic        a_x_valid, a_x_ready, a_w_req, a_w_valid, a_y_valid, a_y_ready, a_busy;
   logic [8:0]  a_x_in, a_x_state, a_layer_y, a_y_out;
   logic [1:0]  a_w_addr;
   logic [26:0] a_w_in, a_w_out;
   logic [3:0]  a_trit;
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
   logic [31:0] a_stall, b_stall;
`endif

   // ---------------- instance B signals ----------------
   logic        b_x_valid, b_x_ready, b_w_req, b_w_valid, b_y_valid, b_y_ready, b_busy;
   logic [8:0]  b_x_in, b_x_state, b_layer_y, b_y_out;
   logic [1:0]  b_w_addr;
   logic [26:0] b_w_in, b_w_out;
   logic [3:0]  b_trit;

   assign a_layer_y = ~a_x_state;
   assign b_layer_y = ~b_x_state;

   interweave_sequencer #(
      .X_SIZE(9), .W_SIZE(27), .TRIT_SIZE(4), .NUM_LAYERS(2), .NUM_PASSES(2)
   ) dut_a (
      .clk_in(clk), .rst_in_n(rst_n),
      .x_valid_in(a_x_valid), .x_ready_out(a_x_ready), .x_in(a_x_in),
      .w_req_out(a_w_req), .w_addr_out(a_w_addr), .w_valid_in(a_w_valid), .w_in(a_w_in),
      .x_state_out(a_x_state), .w_out(a_w_out), .trit_out(a_trit), .layer_y_in(a_layer_y),
      .y_valid_out(a_y_valid), .y_ready_in(a_y_ready), .y_out(a_y_out), .busy_out(a_busy)
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
      , .stall_cnt_out(a_stall)
`endif
   );

   interweave_sequencer #(
      .X_SIZE(9), .W_SIZE(27), .TRIT_SIZE(4), .NUM_LAYERS(3), .NUM_PASSES(1)
   ) dut_b (
      .clk_in(clk), .rst_in_n(rst_n),
      .x_valid_in(b_x_valid), .x_ready_out(b_x_ready), .x_in(b_x_in),
      .w_req_out(b_w_req), .w_addr_out(b_w_addr), .w_valid_in(b_w_valid), .w_in(b_w_in),
      .x_state_out(b_x_state), .w_out(b_w_out), .trit_out(b_trit), .layer_y_in(b_layer_y),
      .y_valid_out(b_y_valid), .y_ready_in(b_y_ready), .y_out(b_y_out), .busy_out(b_busy)
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
      , .stall_cnt_out(b_stall)
`endif
   );

   int errors = 0;
   int checks = 0;

   // weight store behaviour for instance A, set by the main sequence
   int mem_lat  = 1;
   bit spurious = 1'b0;
   bit in_abort = 1'b0;

   logic [8:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- weight store A ----------------
   logic [1:0] ra_addr;
   initial begin
      a_w_valid = 1'b0;
      a_w_in    = '0;
      forever begin
         @(negedge clk);
         if (a_w_req) begin
            ra_addr = a_w_addr;
            repeat (mem_lat) @(posedge clk);
            #1;
            a_w_valid = 1'b1;
            a_w_in    = 27'(ra_addr);
            @(posedge clk);
            #1;
            // optionally keep valid high through APPLY with a junk word
            if (spurious) a_w_in = '1;
            else          a_w_valid = 1'b0;
            @(posedge clk);
            #1;
            a_w_valid = 1'b0;
            if (!in_abort) chk("w_out_latched", 32'(a_w_out), 32'(ra_addr));
         end
      end
   end

   // ---------------- weight store B ----------------
   logic [1:0] rb_addr;
   initial begin
      b_w_valid = 1'b0;
      b_w_in    = '0;
      forever begin
         @(negedge clk);
         if (b_w_req) begin
            rb_addr = b_w_addr;
            @(posedge clk);
            #1;
            b_w_valid = 1'b1;
            b_w_in    = 27'(rb_addr);
            @(posedge clk);
            #1;
            b_w_valid = 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard A ----------------
   int         m_step = 0;
   logic [8:0] m_x    = '0;
   logic [8:0] m_exp;
   logic [8:0] m_pop;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_step = 0;
         end else begin
            if (a_x_valid && a_x_ready) begin
               m_step = 0;
               m_x    = a_x_in;
            end
            if (a_w_req) begin
               m_exp = ((m_step % 2) == 1) ? ~m_x : m_x;
               chk("w_addr_seq", 32'(a_w_addr), 32'(m_step));
               chk("trit_seq", 32'(a_trit), 32'(m_step % 2));
               chk("x_state_step", 32'(a_x_state), 32'(m_exp));
               m_step++;
            end
            if (a_y_valid && a_y_ready) begin
               chk("w_req_count", 32'(m_step), 32'(TOTAL_A));
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
               chk("stall_cnt", a_stall, 32'(TOTAL_A * (mem_lat - 1)));
`endif
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL y_unexpected: got y_out=%0h with nothing expected", a_y_out);
               end else begin
                  m_pop = sb.pop_front();
                  checks--;
                  chk("y_out", 32'(a_y_out), 32'(m_pop));
               end
            end
         end
      end
   end

   // one complete transaction on instance A, with fixed weight latency
   task automatic run_a(input logic [8:0] x, input logic [8:0] ey, input bit early_rdy);
      int cyc;
      @(posedge clk);
      #1;
      a_y_ready = early_rdy;
      a_x_in    = x;
      a_x_valid = 1'b1;
      @(negedge clk);
      chk("a_accept_ready", 32'(a_x_ready), 32'd1);
      sb.push_back(ey);
      @(posedge clk);
      #1;
      a_x_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!a_y_valid && cyc < 300);
      chk("a_latency", 32'(cyc), 32'(TOTAL_A * (mem_lat + 2) + 1));
      if (!early_rdy) begin
         @(posedge clk);
         #1;
         a_y_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      a_y_ready = 1'b0;
      @(negedge clk);
      chk("a_idle_after", 32'(a_x_ready), 32'd1);
   endtask

   typedef struct {
      logic [8:0] x;
      int         lat;
      bit         spur;
      bit         early;
      logic [8:0] y;
   } vec_t;

   vec_t tbl[4];

   // ---------------- main sequence ----------------
   initial begin
      int cyc;

      tbl[0] = '{x: 9'h0A5, lat: 1, spur: 1'b0, early: 1'b0, y: 9'h0A5};
      tbl[1] = '{x: 9'h1FF, lat: 2, spur: 1'b0, early: 1'b1, y: 9'h1FF};
      tbl[2] = '{x: 9'h000, lat: 1, spur: 1'b1, early: 1'b0, y: 9'h000};
      tbl[3] = '{x: 9'h13C, lat: 4, spur: 1'b0, early: 1'b0, y: 9'h13C};

      rst_n     = 1'b0;
      a_x_valid = 1'b0; a_x_in = '0; a_y_ready = 1'b0;
      b_x_valid = 1'b0; b_x_in = '0; b_y_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_x_ready", 32'(a_x_ready), 32'd1);
      chk("rst_w_req", 32'(a_w_req), 32'd0);
      chk("rst_y_valid", 32'(a_y_valid), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_x_state", 32'(a_x_state), 32'd0);
      chk("rst_b_x_ready", 32'(b_x_ready), 32'd1);
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
      chk("rst_stall", a_stall, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // table-driven transactions on A
      for (int i = 0; i < 4; i++) begin
         mem_lat  = tbl[i].lat;
         spurious = tbl[i].spur;
         run_a(tbl[i].x, tbl[i].y, tbl[i].early);
      end
      spurious = 1'b0;
      mem_lat  = 1;

      // B: three inversions, result held while downstream stalls
      @(posedge clk);
      #1;
      b_x_in    = 9'h1FF;
      b_x_valid = 1'b1;
      @(negedge clk);
      chk("b_accept_ready", 32'(b_x_ready), 32'd1);
      @(posedge clk);
      #1;
      b_x_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!b_y_valid && cyc < 300);
      chk("b_latency", 32'(cyc), 32'(TOTAL_B * 3 + 1));
      chk("b_done_trit", 32'(b_trit), 32'd2);
      chk("b_done_w", 32'(b_w_out), 32'd2);
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
      chk("b_stall", b_stall, 32'd0);
`endif
      for (int i = 0; i < 5; i++) begin
         chk("b_y_hold_valid", 32'(b_y_valid), 32'd1);
         chk("b_y_out", 32'(b_y_out), 32'h000);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      b_y_ready = 1'b1;
      @(negedge clk);
      chk("b_hs_valid", 32'(b_y_valid), 32'd1);
      chk("b_hs_not_ready", 32'(b_x_ready), 32'd0);
      @(posedge clk);
      #1;
      b_y_ready = 1'b0;
      @(negedge clk);
      chk("b_idle_ready", 32'(b_x_ready), 32'd1);
      chk("b_idle_busy", 32'(b_busy), 32'd0);

      // A: x_valid held high through DONE; second vector waits for handshake
      @(posedge clk);
      #1;
      a_x_in    = 9'h0C3;
      a_x_valid = 1'b1;
      @(negedge clk);
      chk("hold_accept1", 32'(a_x_ready), 32'd1);
      sb.push_back(9'h0C3);
      @(posedge clk);
      #1;
      a_x_in = 9'h03C;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         chk("hold_busy_no_accept", 32'(a_x_ready), 32'd0);
      end while (!a_y_valid && cyc < 300);
      @(posedge clk);
      #1;
      a_y_ready = 1'b1;
      @(negedge clk);
      chk("hold_hs_not_ready", 32'(a_x_ready), 32'd0);
      @(posedge clk);
      #1;
      a_y_ready = 1'b0;
      @(negedge clk);
      chk("hold_accept2", 32'(a_x_ready), 32'd1);
      sb.push_back(9'h03C);
      @(posedge clk);
      #1;
      a_x_valid = 1'b0;
      @(negedge clk);
      chk("hold_busy2", 32'(a_busy), 32'd1);
      chk("hold_x_state2", 32'(a_x_state), 32'h03C);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!a_y_valid && cyc < 300);
      chk("hold_done2", 32'(a_y_valid), 32'd1);
      @(posedge clk);
      #1;
      a_y_ready = 1'b1;
      @(posedge clk);
      #1;
      a_y_ready = 1'b0;

      // A: reset asserted during WAIT_W of step 2
      mem_lat = 4;
      @(posedge clk);
      #1;
      a_x_in    = 9'h155;
      a_x_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      a_x_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(a_w_req && a_w_addr == 2'd2) && cyc < 300);
      chk("abort_reach_step2", 32'(a_w_req && a_w_addr == 2'd2), 32'd1);
      in_abort = 1'b1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_x_ready", 32'(a_x_ready), 32'd1);
      chk("abort_w_req", 32'(a_w_req), 32'd0);
      chk("abort_w_addr", 32'(a_w_addr), 32'd0);
      chk("abort_x_state", 32'(a_x_state), 32'd0);
      chk("abort_w_out", 32'(a_w_out), 32'd0);
      chk("abort_trit", 32'(a_trit), 32'd0);
      chk("abort_y_valid", 32'(a_y_valid), 32'd0);
      chk("abort_y_out", 32'(a_y_out), 32'd0);
      chk("abort_busy", 32'(a_busy), 32'd0);
`ifdef INTERWEAVE_SEQ_STALL_CNT_EN
      chk("abort_stall", a_stall, 32'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("late_w_busy", 32'(a_busy), 32'd0);
         chk("late_w_out", 32'(a_w_out), 32'd0);
      end
      in_abort = 1'b0;
      mem_lat  = 1;
      run_a(9'h0F0, 9'h0F0, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
